// File: rtl/pc_pkg.sv
// pc_pkg: shared constants and the next-PC source encoding used by the
// program-counter sequencer and its return-address stack.
package pc_pkg;

  localparam int          ADDR_W_DEF    = 32;
  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
  localparam logic [31:0] EXC_VEC_DEF   = 32'h0000_0080;
  localparam int          INC_DEF       = 4;
  localparam int          RAS_DEPTH_DEF = 4;

  // Where the next PC comes from this cycle.
  typedef enum logic [2:0] {
    SRC_SEQ,    // PC + INC
    SRC_HOLD,   // stalled
    SRC_REDIR,  // branch/jump target
    SRC_RET,    // return-address stack top
    SRC_EXC,    // exception vector
    SRC_PEND    // redirect buffered during a stall
  } next_src_e;

endpackage

// File: rtl/ras_stack.sv
// ras_stack: circular return-address LIFO.
//   push_i          write data_i as the new top
//   pop_i           discard the top (ignored while empty, flags underflow)
//   push_i & pop_i  replace the top in place, count unchanged
// A push while full overwrites the oldest entry and sets the sticky ovf_o.
// Outputs: top_o, count_o, registered full_o/empty_o, sticky ovf_o/unf_o.
// Clock Clk, synchronous active-high Reset.
module ras_stack #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             data_i,
  output logic [W-1:0]             top_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     ovf_o,
  output logic                     unf_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [PW-1:0]           tp_q, tp_d, wr_idx;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    full_q, empty_q, ovf_q, unf_q;
  logic                    do_pop, wr_en;

  assign do_pop = pop_i && !empty_q;

  always_comb begin
    tp_d   = tp_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = tp_q;
    if (push_i && do_pop) begin
      wr_en = 1'b1;                   // pop then push == overwrite top
    end else if (push_i) begin
      wr_en  = 1'b1;
      wr_idx = tp_q + 1'b1;           // when full this slot holds the oldest entry
      tp_d   = tp_q + 1'b1;
      if (!full_q) cnt_d = cnt_q + 1'b1;
    end else if (do_pop) begin
      tp_d  = tp_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      tp_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      tp_q    <= tp_d;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == CW'(DEPTH));
      empty_q <= (cnt_d == '0);
      ovf_q   <= ovf_q | (push_i && !do_pop && full_q);
      unf_q   <= unf_q | (pop_i && empty_q);
    end
  end

  // Contents need no reset; count/pointer define validity.
  always_ff @(posedge Clk) begin
    if (wr_en) mem_q[wr_idx] <= data_i;
  end

  assign top_o   = mem_q[tp_q];
  assign count_o = cnt_q;
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign ovf_o   = ovf_q;
  assign unf_o   = unf_q;

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch program counter with stall hold, branch/jump redirect,
// exception vectoring and call/return through a return-address stack.
// Inputs : Clk, Reset (sync, active-high), Stall, Redir_Valid, Redir_Addr,
//          Call, Ret, Exception.
// Outputs: PC (registered), PCPlus (PC+INC, combinational), Pending,
//          RAS_Empty, RAS_Full, Ras_Ovf, Ras_Unf.
// A control transfer seen during a stall is captured in a one-entry buffer
// and applied on release; only an exception may overwrite that buffer.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(RESET_VEC_DEF),
  parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(EXC_VEC_DEF),
  parameter int                INC       = INC_DEF,
  parameter int                RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Stall,
  input  logic              Redir_Valid,
  input  logic [ADDR_W-1:0] Redir_Addr,
  input  logic              Call,
  input  logic              Ret,
  input  logic              Exception,
  output logic [ADDR_W-1:0] PC,
  output logic [ADDR_W-1:0] PCPlus,
  output logic              Pending,
  output logic              RAS_Empty,
  output logic              RAS_Full,
  output logic              Ras_Ovf,
  output logic              Ras_Unf
);

  logic [ADDR_W-1:0]          pc_q, pc_d, buf_q, buf_d, tgt, ras_top;
  logic                       pend_q, pend_d, has_tgt, accept, ras_push, ras_pop;
  logic [$clog2(RAS_DEPTH):0] ras_cnt;
  next_src_e                  src;

  assign PCPlus = pc_q + ADDR_W'(INC);

  // Prioritised target for this cycle; a Ret with nothing stacked is no target.
  always_comb begin
    has_tgt = 1'b1;
    tgt     = EXC_VEC;
    if (Exception)           tgt = EXC_VEC;
    else if (Redir_Valid)    tgt = Redir_Addr;
    else if (Ret && ras_cnt != '0) tgt = ras_top;
    else                     has_tgt = 1'b0;
  end

  always_comb begin
    src    = SRC_SEQ;
    pend_d = pend_q;
    buf_d  = buf_q;
    // Requests are accepted (RAS side effects happen) only when no redirect
    // is already buffered; an exception leaves the RAS alone.
    accept = !pend_q && !Exception;
    if (Stall) begin
      src = SRC_HOLD;
      if (!pend_q && has_tgt) begin
        pend_d = 1'b1;
        buf_d  = tgt;
      end else if (pend_q && Exception) begin
        buf_d = EXC_VEC;
      end
    end else if (pend_q) begin
      src    = Exception ? SRC_EXC : SRC_PEND;
      pend_d = 1'b0;
    end else if (Exception)   src = SRC_EXC;
    else if (Redir_Valid)     src = SRC_REDIR;
    else if (has_tgt)         src = SRC_RET;
    ras_push = accept && Redir_Valid && Call;
    ras_pop  = accept && Ret;
  end

  always_comb begin
    pc_d = PCPlus;
    case (src)
      SRC_HOLD:  pc_d = pc_q;
      SRC_REDIR: pc_d = Redir_Addr;
      SRC_RET:   pc_d = ras_top;
      SRC_EXC:   pc_d = EXC_VEC;
      SRC_PEND:  pc_d = buf_q;
      default:   pc_d = PCPlus;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q   <= RESET_VEC;
      pend_q <= 1'b0;
      buf_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      pend_q <= pend_d;
      buf_q  <= buf_d;
    end
  end

  ras_stack #(.W(ADDR_W), .DEPTH(RAS_DEPTH)) u_ras (
    .Clk     (Clk),
    .Reset   (Reset),
    .push_i  (ras_push),
    .pop_i   (ras_pop),
    .data_i  (PCPlus),
    .top_o   (ras_top),
    .count_o (ras_cnt),
    .full_o  (RAS_Full),
    .empty_o (RAS_Empty),
    .ovf_o   (Ras_Ovf),
    .unf_o   (Ras_Unf)
  );

  assign PC      = pc_q;
  assign Pending = pend_q;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised next-generation program counter for the single-cycle and pipelined datapaths. It holds the fetch address and advances by a fixed increment. It also handles stall hold, branch/jump redirect, exception vectoring, and call/return through an internal return-address stack (RAS). Redirects that arrive during a stall are buffered and applied when the stall releases, so no control transfer is lost.

Parameters:
ADDR_W, 32, width of PC and all address ports
RESET_VEC, 0, PC value after reset
EXC_VEC, 32'h0000_0080, exception handler address
INC, 4, sequential increment (bytes)
RAS_DEPTH, 4, return-address stack entries (power of 2, >=2)

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  synchronous, active-high
Stall  in  1  hold PC; buffer any redirect
Redir_Valid  in  1  branch/jump taken this cycle
Redir_Addr  in  ADDR_W  branch/jump target
Call  in  1  qualified by Redir_Valid; push PC+INC onto RAS
Ret  in  1  pop RAS; next PC = popped value
Exception  in  1  vector to EXC_VEC
PC  out  ADDR_W  current fetch address (registered)
PCPlus  out  ADDR_W  PC+INC (combinational)
Pending  out  1  a redirect is buffered during stall
RAS_Empty  out  1  stack holds 0 entries
RAS_Full  out  1  stack holds RAS_DEPTH entries
Ras_Ovf  out  1  sticky: push while full
Ras_Unf  out  1  sticky: Ret while empty

Behaviour:
- Reset is synchronous and active-high; clock is Clk. On Reset: PC=RESET_VEC, Pending=0, RAS count=0, RAS_Empty=1, RAS_Full=0, Ras_Ovf=0, Ras_Unf=0. Reset beats every other input. A mid-stall Reset discards the pending redirect.
- Arithmetic is modulo 2^ADDR_W. PC+INC wraps silently at the top of the address space.
- The next-target T is chosen per cycle by priority: Exception -> EXC_VEC; Redir_Valid -> Redir_Addr; Ret -> RAS top; otherwise none.
- Stall=0, no pending redirect: PC <= T if one exists, else PCPlus. Latency is one cycle (target visible on PC the cycle after assertion).
- Stall=0 with Pending=1: PC <= buffered address and Pending <= 0. A new Exception in the same cycle overrides the buffer (PC <= EXC_VEC). A new Redir_Valid in that cycle is ignored. The buffered address is older, and the front end must not issue one.
- Stall=1: PC holds.
  - If T exists and Pending=0, store T and set Pending=1.
  - If Pending=1 already, only an Exception overwrites the buffer (with EXC_VEC). Other redirects are dropped.
- RAS side effects occur in the cycle the request is accepted: a live cycle, or the cycle it is captured into the buffer. Side effects are never repeated when the buffer drains.
  - Call: requires Redir_Valid. Pushes PCPlus of the current PC. Call without Redir_Valid is ignored.
  - Push while full: overwrite the oldest entry (circular), count stays RAS_DEPTH, set Ras_Ovf.
  - Ret while empty: no pop, no redirect (PC sequential or hold), set Ras_Unf.
  - Call and Ret together (with Redir_Valid): the redirect wins. Perform the pop, then the push, so the top is replaced and count is unchanged.
  - Exception with Call/Ret: the Exception wins and the RAS is untouched.
- RAS_Empty and RAS_Full are registered flags derived from the count. Sticky flags clear only on Reset.

Decomposition:
- Shared package pc_pkg: ADDR_W default, RESET_VEC, EXC_VEC, INC constants; a next-PC source enum {SRC_SEQ, SRC_HOLD, SRC_REDIR, SRC_RET, SRC_EXC, SRC_PEND}.
- One natural sub-module, ras_stack: a circular LIFO with push, pop, and push+pop replace, plus top, count, full, empty and overflow outputs.
- The top level holds the PC register, the pending buffer and the priority mux.

Test Plan:
1. Reset, then 3 free-running cycles -> PC = 0, 4, 8, C; RAS_Empty=1; all flags 0.
2. At PC=0x10, Redir_Valid+Call, Redir_Addr=0x100 -> next PC=0x100, RAS top=0x14. At 0x104 pulse Ret -> PC=0x14, RAS_Empty=1.
3. Stall=1 at PC=0x20 with a 1-cycle Redir_Valid to 0x200, Stall held 3 cycles -> PC stays 0x20 and Pending=1. The first unstalled cycle gives PC=0x200, then Pending=0.
4. During Pending (buffer=0x200) assert Exception with Stall=1 -> buffer becomes 0x80. On release PC=0x80 and the RAS is unchanged.
5. RAS_DEPTH=4: make 5 calls from PCs 0x0, 0x100, 0x200, 0x300, 0x400 -> RAS_Full=1, Ras_Ovf=1. Five Rets return 0x404, 0x304, 0x204, 0x104; the fifth Ret is sequential with Ras_Unf=1.
6. Load PC=0xFFFF_FFFC via redirect, then one free cycle -> PC=0x0 (wrap). Reset asserted together with Exception -> PC=RESET_VEC.
